// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, legal width
// range and the bit-counter width derivation.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Counter must be able to hold every bit index 0..WIDTH-1 and the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder: the single arithmetic slice reused by the serial adder
// and by other bit-serial blocks of the arithmetic library.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full
// adder and a carry flip-flop; the result is registered and announced by Done_Out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_n_In,
    input  logic             Start_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    input  logic             Carry_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Sum_Out,
    output logic             Carry_Out
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             carry_out_q;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             last;
    logic             bit_sum;
    logic             bit_carry;

    full_adder_cell u_bit_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    assign last = (cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start_In) begin
                    load      = 1'b1;
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: all datapath registers are reset, because an aborted operation
    // must not leak a partial sum or stale carry into the visible outputs.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else if (load) begin
            a_sh    <= Data_A_In;
            b_sh    <= Data_B_In;
            carry_q <= Carry_In;
            acc     <= '0;
            cnt     <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= bit_carry;
            acc     <= {bit_sum, acc[WIDTH-1:1]};
            cnt     <= cnt + 1'b1;
            // The final slice goes straight into the result register.
            if (last) begin
                sum_q       <= {bit_sum, acc[WIDTH-1:1]};
                carry_out_q <= bit_carry;
            end
        end
    end

    assign Busy_Out  = (state != ST_IDLE);
    assign Done_Out  = (state == ST_DONE);
    assign Sum_Out   = sum_q;
    assign Carry_Out = carry_out_q;

endmodule
